vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster source for the VGA path: generates pixel coordinates, hsync/vsync and a one-cycle
//  frame tick, samples the renderer's draw bit, and produces the registered RGB pixel.
//  Sits between the pixel clock and a draw-bit renderer (e.g. the Pong generator).
//  It drives that renderer's pix_x/pix_y/en inputs and consumes its draw output.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (clocks)
//  H_SYNC    96   hsync pulse width (clocks)
//  H_BP      48   horizontal back porch (clocks)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    sync active level (0 = active-low, VGA 640x480 default)
//  DRAW_LAT  0    cycles from pix_x/pix_y valid to draw valid (0..4)
// PORTS
//  clk          in   1   pixel clock, one pixel per cycle (25 MHz nominal)
//  rst          in   1   reset, synchronous, active-high
//  pix_x        out  10  horizontal counter (0..H_TOTAL-1)
//  pix_y        out  10  vertical counter (0..V_TOTAL-1)
//  display_on   out  1   combinational: pix_x<H_ACTIVE && pix_y<V_ACTIVE
//  frame_tick   out  1   one-cycle pulse per frame; drives renderer en
//  frame_count  out  8   frames completed since reset, wraps
//  draw         in   1   renderer pixel-on bit, valid DRAW_LAT cycles after pix_x/pix_y
//  fg_rgb       in   6   colour used when draw=1 ({R1,R0,G1,G0,B1,B0})
//  bg_rgb       in   6   colour used when draw=0 inside the active area
//  hsync        out  1   registered horizontal sync
//  vsync        out  1   registered vertical sync
//  rgb          out  6   registered pixel colour
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
//    Both totals must be <= 1024; this is elaborate-time checked.
//  - Horizontal counter: increments every clk and wraps H_TOTAL-1 -> 0.
//  - Vertical counter: increments when the horizontal counter wraps, and itself wraps V_TOTAL-1 -> 0.
//  - Reset: counters=0, frame_tick=0, frame_count=0, rgb=0. hsync and vsync sit at the inactive
//    level (~SYNC_POL). All alignment pipeline stages are cleared to inactive/blank.
//  - First cycle after reset is released: pix_x=0, pix_y=0.
//  - Raw sync (combinational from the counters):
//    h_sync_raw = pix_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//    v_sync_raw = pix_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//  - frame_tick: combinational, 1 exactly when pix_x==0 && pix_y==V_ACTIVE, i.e. the first
//    blanking clock. The renderer therefore updates state once per frame, outside active video.
//  - frame_count: increments on the clock edge where frame_tick=1; 8'hFF wraps to 8'h00.
//  - Alignment: display_on, h_sync_raw and v_sync_raw pass through a DRAW_LAT-deep shift
//    register so they line up with draw. A final output register then computes:
//    rgb   <= on_d ? (draw ? fg_rgb : bg_rgb) : 6'h00
//    hsync <= hs_d ^ ~SYNC_POL
//    vsync <= vs_d ^ ~SYNC_POL
//  - Latency: hsync, vsync and rgb are DRAW_LAT+1 cycles after the corresponding counter value.
//    All three share that latency, so they never skew relative to each other.
//  - fg_rgb and bg_rgb are sampled in the output-register cycle; they are not delayed.
//  - rgb is forced to 0 in all blanking, including porches and sync, regardless of draw.
//  - rst asserted mid-frame: on the next edge, counters=0 and frame_count=0. Pipeline stages
//    are blanked, so no partial line or stale colour is emitted. Restart is a full new frame.
//  - There is no clock enable and no back-pressure; the raster free-runs.
// TESTING
//  T1 reset: hold rst 3 clk, DRAW_LAT=0
//     -> pix_x=0, pix_y=0, hsync=vsync=1, rgb=0, frame_count=0
//     -> after release, pix_x steps 0,1,2
//  T2 line timing, defaults, DRAW_LAT=0
//     -> hsync falling-edge period = 800 clk; low width = 96 clk
//     -> falling edge on the edge after pix_x==656
//  T3 frame timing
//     -> vsync low for exactly 1600 clk; frame period = 420000 clk
//     -> exactly one frame_tick per frame, at pix_x=0, pix_y=480; frame_count 0 -> 1
//  T4 colour: draw=1, fg=6'h3F, bg=6'h01, DRAW_LAT=2
//     -> rgb=3F from 3 clk after pix_x=0 through 3 clk after pix_x=639
//     -> rgb=00 from 3 clk after pix_x=640; draw=0 gives 01 in active area
//  T5 reset mid-frame at pix_x=300, pix_y=200 with rgb non-zero
//     -> next cycle pix_x=0, pix_y=0, rgb=0, frame_count=0, syncs inactive
//  T6 reduced params (H 8/1/2/1, V 4/1/1/1, totals 12x7)
//     -> run 256 frames; frame_count wraps FF->00; frame_tick period = 84 clk

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster source for the VGA path. Free-running horizontal and
//             vertical counters, hsync/vsync generation, a one-cycle frame
//             tick for the renderer, and a registered RGB pixel built from
//             the renderer's draw bit.
//  Ports    : clk, rst           pixel clock, synchronous active-high reset
//             pix_x, pix_y       raster coordinates (to renderer)
//             display_on         combinational active-area flag
//             frame_tick         one-cycle pulse at first blanking clock
//             frame_count        frames completed since reset (wraps)
//             draw               renderer pixel-on bit, DRAW_LAT cycles late
//             fg_rgb, bg_rgb     foreground / background colours
//             hsync, vsync, rgb  registered video outputs
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int DRAW_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       display_on,
    output logic       frame_tick,
    output logic [7:0] frame_count,
    input  logic       draw,
    input  logic [5:0] fg_rgb,
    input  logic [5:0] bg_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    localparam int c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start   = H_ACTIVE + H_FP;
    localparam int c_hs_end     = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_start   = V_ACTIVE + V_FP;
    localparam int c_vs_end     = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [9:0] c_h_last = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last = 10'(c_v_total - 1);

    // Counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
        end
        if (DRAW_LAT < 0 || DRAW_LAT > 4) begin : g_bad_lat
            $error("vga_timing_gen: DRAW_LAT must be in 0..4");
        end
    endgenerate

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [7:0] r_frame_count;
    logic       r_hsync;
    logic       r_vsync;
    logic [5:0] r_rgb;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [2:0] w_raw;      // {display_on, hs_raw, vs_raw}
    logic [2:0] w_aligned;  // same, delayed to line up with draw

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    assign w_h_last = (r_h_cnt == c_h_last);
    assign w_v_last = (r_v_cnt == c_v_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end

    assign pix_x = r_h_cnt;
    assign pix_y = r_v_cnt;

    // Comparisons are done in int so a porch end of exactly 1024 still works.
    assign display_on = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign w_hs_raw   = (int'(r_h_cnt) >= c_hs_start) && (int'(r_h_cnt) < c_hs_end);
    assign w_vs_raw   = (int'(r_v_cnt) >= c_vs_start) && (int'(r_v_cnt) < c_vs_end);

    // First blanking clock of the frame: the renderer updates its state here,
    // well clear of active video.
    assign frame_tick = (r_h_cnt == 10'd0) && (int'(r_v_cnt) == V_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (frame_tick) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;

    // ------------------------------------------------------------------
    // Alignment pipeline: delays the timing flags by the renderer latency.
    // Cleared to zero on reset, which reads as blank / sync inactive.
    // ------------------------------------------------------------------
    assign w_raw = {display_on, w_hs_raw, w_vs_raw};

    generate
        if (DRAW_LAT == 0) begin : g_no_delay
            assign w_aligned = w_raw;
        end else begin : g_delay
            logic [2:0] r_pipe [DRAW_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DRAW_LAT; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < DRAW_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_aligned = r_pipe[DRAW_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: colours are sampled here, undelayed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_rgb   <= w_aligned[2] ? (draw ? fg_rgb : bg_rgb) : 6'h00;
            r_hsync <= w_aligned[1] ^ ~SYNC_POL;
            r_vsync <= w_aligned[0] ^ ~SYNC_POL;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign rgb   = r_rgb;

endmodule
`default_nettype wire
